// File: rtl/csa_acc_pkg.sv
// ============================================================================
// Module   : csa_acc_pkg
// Brief    : Shared FSM state encoding and default widths for csa_accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package csa_acc_pkg;

    localparam int C_WIDTH     = 8;
    localparam int C_ACC_WIDTH = 16;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/no_ripple_N_full_adder.sv
// ============================================================================
// Module   : no_ripple_N_full_adder
// Brief    : WIDTH independent full adders (3:2 compressor), no carry chain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module no_ripple_N_full_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    output logic [WIDTH-1:0] o_sum,
    output logic [WIDTH-1:0] o_carry
);

    assign o_sum   = i_a ^ i_b ^ i_c;
    assign o_carry = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

`default_nettype wire

// File: rtl/csa_accumulator.sv
// ============================================================================
// Module   : csa_accumulator
// Brief    : Packet accumulator holding a carry-save sum, resolved carry-by-carry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_accumulator
    import csa_acc_pkg::*;
#(
    parameter int WIDTH     = C_WIDTH,
    parameter int ACC_WIDTH = C_ACC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    input  logic                 soft_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [7:0]           out_count
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [ACC_WIDTH-1:0]   r_s;
    logic [ACC_WIDTH-1:0]   r_c;
    logic [ACC_WIDTH-1:0]   r_out_data;
    logic [7:0]             r_count;
    logic [ACC_WIDTH-1:0]   w_fa_c;
    logic [ACC_WIDTH-1:0]   w_sum;
    logic [ACC_WIDTH-1:0]   w_carry;
    logic [ACC_WIDTH-1:0]   w_carry_sh;
    logic                   w_accept;
    logic                   w_c_zero;

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == DONE);
    assign out_data  = r_out_data;
    assign out_count = r_count;
    assign w_accept  = in_valid && in_ready;
    assign w_c_zero  = (r_c == '0);

    // Single compressor: adds the operand in ACCUM, acts as a half-adder step in RESOLVE.
    assign w_fa_c     = (r_state == ACCUM) ? {{(ACC_WIDTH-WIDTH){1'b0}}, in_data} : '0;
    assign w_carry_sh = w_carry << 1;

    no_ripple_N_full_adder #(
        .WIDTH (ACC_WIDTH)
    ) u_fa (
        .i_a     (r_s),
        .i_b     (r_c),
        .i_c     (w_fa_c),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (soft_clr) begin
            w_next_state = ACCUM;
        end else begin
            case (r_state)
                ACCUM:   if (w_accept && in_last) w_next_state = RESOLVE;
                RESOLVE: if (w_c_zero)            w_next_state = DONE;
                DONE:    if (out_ready)           w_next_state = ACCUM;
                default:                          w_next_state = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s        <= '0;
            r_c        <= '0;
            r_out_data <= '0;
            r_count    <= '0;
        end else if (soft_clr) begin
            r_s        <= '0;
            r_c        <= '0;
            r_out_data <= '0;
            r_count    <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        r_s     <= w_sum;
                        r_c     <= w_carry_sh;
                        r_count <= (r_count == 8'hFF) ? r_count : r_count + 8'd1;
                    end
                end
                RESOLVE: begin
                    if (w_c_zero) begin
                        r_out_data <= r_s;
                    end else begin
                        r_s <= w_sum;
                        r_c <= w_carry_sh;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_s     <= '0;
                        r_c     <= '0;
                        r_count <= '0;
                    end
                end
                default: begin
                    r_s <= '0;
                    r_c <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
